ahb_sram_slave: RTL and testbench



---
 rtl/ahb_sram_slave_if.sv | 36 +++
 rtl/ahb_sram_slave.sv | 151 +++++++++++++++
 tb/tb_ahb_sram_slave.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_sram_slave_if.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave_if
// AHB-Lite signal bundle between one initiator and the ahb_sram_slave.
//
// Handshake: an address phase is offered when hsel & htrans[1] is high and is
// taken on the rising hclk edge where hready_in is also high. The data phase
// that follows completes on the first edge where hready_out is high. hwdata is
// driven by the initiator for the whole data phase. hresp and hrdata are only
// meaningful while the data phase is in progress.
//
// Signals:
//   hsel, htrans, hwrite, haddr, hsize, hwdata, hready_in : initiator -> slave
//   hready_out, hresp, hrdata                            : slave -> initiator
// ---------------------------------------------------------------------------
interface ahb_sram_slave_if;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready_in;
  logic        hready_out;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  modport slave (
    input  hsel, htrans, hwrite, haddr, hsize, hwdata, hready_in,
    output hready_out, hresp, hrdata
  );

  modport master (
    output hsel, htrans, hwrite, haddr, hsize, hwdata, hready_in,
    input  hready_out, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// ahb_sram_slave
// AHB-Lite responder backing a word-organised array of DEPTH 32-bit words with
// byte/half/word access, optional wait states on OKAY transfers and a
// two-cycle ERROR response for illegal accesses.
//
// Ports:
//   hclk      : clock
//   rst_n     : synchronous, active-low reset
//   bus       : AHB-Lite slave modport (see ahb_sram_slave_if)
//   dbg_state : current FSM state (0 IDLE, 1 WAIT, 2 ERR1, 3 ERR2)
// ---------------------------------------------------------------------------
module ahb_sram_slave #(
  parameter int DEPTH       = 1024,
  parameter int AW          = 12,
  parameter int WAIT_STATES = 0,
  parameter int INIT_ZERO   = 1
) (
  input  logic               hclk,
  input  logic               rst_n,
  ahb_sram_slave_if.slave    bus,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  localparam int             IW    = AW - 2;
  localparam logic [3:0]     WS    = 4'(WAIT_STATES);
  localparam logic [AW:0]    BYTES = (AW+1)'(DEPTH * 4);

  state_t          state, state_nxt;
  logic [3:0]      cnt;
  logic            dp_valid;   // a legal data phase is in progress
  logic            dp_write;
  logic [AW-1:0]   dp_addr;
  logic [1:0]      dp_size;
  logic [3:0]      be;
  logic [IW-1:0]   widx;
  logic [31:0]     mem [DEPTH];

  // Address phases are only taken when the previous data phase is at its
  // last cycle (IDLE) or in the second ERROR cycle, which both drive
  // hready_out high.
  logic addr_open, take, illegal, take_ok, take_err;
  logic size_bad, misalign, range_bad, high_bad;

  assign addr_open = (state == S_IDLE) || (state == S_ERR2);
  assign take      = bus.hsel & bus.hready_in & bus.htrans[1] & addr_open;

  assign size_bad  = bus.hsize > 3'd2;
  assign misalign  = ((bus.hsize == 3'd1) && bus.haddr[0]) ||
                     ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00));
  assign range_bad = {1'b0, bus.haddr[AW-1:0]} >= BYTES;
  assign high_bad  = (bus.haddr >> AW) != 32'd0;
  assign illegal   = size_bad | misalign | range_bad | high_bad;
  assign take_ok   = take & ~illegal;
  assign take_err  = take & illegal;

  assign dbg_state = state;
  assign widx      = dp_addr[AW-1:2];

  // State register.
  always_ff @(posedge hclk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_ERR2: begin
        if (take_err)                  state_nxt = S_ERR1;
        else if (take_ok && WS != 4'd0) state_nxt = S_WAIT;
        else                           state_nxt = S_IDLE;
      end
      S_WAIT:  if (cnt <= 4'd1) state_nxt = S_IDLE;
      S_ERR1:  state_nxt = S_ERR2;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    bus.hready_out = 1'b1;
    bus.hresp      = 2'b00;
    case (state)
      S_WAIT:  bus.hready_out = 1'b0;
      S_ERR1: begin
        bus.hready_out = 1'b0;
        bus.hresp      = 2'b01;
      end
      S_ERR2:  bus.hresp = 2'b01;
      default: ;
    endcase
  end

  // Data-phase bookkeeping and wait counter.
  always_ff @(posedge hclk) begin
    if (!rst_n) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      dp_size  <= '0;
      cnt      <= '0;
    end else begin
      if (addr_open) begin
        dp_valid <= take_ok;
        if (take) begin
          dp_write <= bus.hwrite;
          dp_addr  <= bus.haddr[AW-1:0];
          dp_size  <= bus.hsize[1:0];
        end
      end
      if (state == S_WAIT) cnt <= cnt - 4'd1;
      else if (take_ok)    cnt <= WS;
    end
  end

  // Little-endian lane enables for the latched transfer.
  always_comb begin
    be = 4'b0000;
    case (dp_size)
      2'd0:    be = 4'b0001 << dp_addr[1:0];
      2'd1:    be = dp_addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // A write commits on the completing cycle (IDLE with a data phase pending),
  // so a read issued right behind it sees the new data.
  always_ff @(posedge hclk) begin
    if (!rst_n) begin
      if (INIT_ZERO != 0) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end
    end else if ((state == S_IDLE) && dp_valid && dp_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= bus.hwdata[8*b +: 8];
      end
    end
  end

  assign bus.hrdata = (dp_valid && !dp_write) ? mem[widx] : 32'd0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// ---------------------------------------------------------------------------
// tb_ahb_sram_slave
// Two responders share one AHB-Lite bus: u_dut0 with no wait states and
// u_dut1 with three. The driver issues pipelined transfers and pushes the
// expected response into exp_q; the monitor walks the bus on negedges and
// compares every data phase (and every idle cycle) against it. The reference
// memory is a plain byte array per responder.
// ---------------------------------------------------------------------------
module tb_ahb_sram_slave;
  localparam int DEPTH = 1024;
  localparam int AW    = 12;
  localparam int W     = 37;  // {err, waits[3:0], rdata[31:0]}

  // ---------------- clock / reset ----------------
  logic hclk  = 1'b0;
  logic rst_n = 1'b0;
  always #5 hclk = ~hclk;

  // ---------------- bus ----------------
  ahb_sram_slave_if bus0();
  ahb_sram_slave_if bus1();

  logic        b_tgt;
  logic        b_hsel;
  logic [1:0]  b_htrans;
  logic        b_hwrite;
  logic [31:0] b_haddr;
  logic [2:0]  b_hsize;
  logic [31:0] b_hwdata;
  logic        dsel;
  logic        bus_hready;
  logic [1:0]  bus_hresp;
  logic [31:0] bus_hrdata;
  logic [1:0]  dbg0, dbg1;

  assign bus0.hsel      = b_hsel & ~b_tgt;
  assign bus1.hsel      = b_hsel & b_tgt;
  assign bus0.htrans    = b_htrans;
  assign bus1.htrans    = b_htrans;
  assign bus0.hwrite    = b_hwrite;
  assign bus1.hwrite    = b_hwrite;
  assign bus0.haddr     = b_haddr;
  assign bus1.haddr     = b_haddr;
  assign bus0.hsize     = b_hsize;
  assign bus1.hsize     = b_hsize;
  assign bus0.hwdata    = b_hwdata;
  assign bus1.hwdata    = b_hwdata;
  assign bus0.hready_in = bus_hready;
  assign bus1.hready_in = bus_hready;

  assign bus_hready = dsel ? bus1.hready_out : bus0.hready_out;
  assign bus_hresp  = dsel ? bus1.hresp      : bus0.hresp;
  assign bus_hrdata = dsel ? bus1.hrdata     : bus0.hrdata;

  // Data-phase owner follows the last accepted address phase.
  always @(posedge hclk) begin
    if (!rst_n)          dsel <= 1'b0;
    else if (bus_hready) dsel <= b_hsel & b_tgt & b_htrans[1];
  end

  ahb_sram_slave #(.DEPTH(DEPTH), .AW(AW), .WAIT_STATES(0), .INIT_ZERO(1)) u_dut0 (
    .hclk(hclk), .rst_n(rst_n), .bus(bus0), .dbg_state(dbg0)
  );
  ahb_sram_slave #(.DEPTH(DEPTH), .AW(AW), .WAIT_STATES(3), .INIT_ZERO(1)) u_dut1 (
    .hclk(hclk), .rst_n(rst_n), .bus(bus1), .dbg_state(dbg1)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [7:0]   mem_m [2][DEPTH*4];
  logic [W-1:0] exp_q [$];
  logic [31:0]  pend_wdata;
  int           n_vec  = 0;
  int           n_miss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, req);
    end
  endtask

  task automatic model_clear();
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < DEPTH*4; i++) mem_m[t][i] = 8'h00;
  endtask

  function automatic logic [31:0] model_word(input logic t, input logic [31:0] a);
    int base;
    base = int'(a & 32'hFFFF_FFFC);
    return {mem_m[t][base+3], mem_m[t][base+2], mem_m[t][base+1], mem_m[t][base]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    b_hsel   = 1'b0;
    b_htrans = 2'b00;
    rst_n    = 1'b0;
    exp_q.delete();
    model_clear();
    pend_wdata = 32'd0;
    repeat (n) @(posedge hclk);
    #1 rst_n = 1'b1;
  endtask

  // Presents one address phase (and the previous transfer's write data),
  // holds it until taken, then updates the model and scoreboard.
  task automatic issue(input logic tgt, input logic sel, input logic [1:0] trans,
                       input logic wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] wdata);
    logic        rdy;
    int          n;
    bit          err;
    logic [31:0] d;
    int          nb;
    int          ba;
    b_hwdata = pend_wdata;
    b_tgt    = tgt;
    b_hsel   = sel;
    b_htrans = trans;
    b_hwrite = wr;
    b_haddr  = addr;
    b_hsize  = size;
    n = 0;
    do begin
      @(negedge hclk);
      rdy = bus_hready;
      @(posedge hclk);
      #1;
      n++;
    end while (!rdy && n < 40);
    if (!rdy) check("accept_timeout", 32'(rdy), 32'd1);
    pend_wdata = $urandom();
    if (rdy && sel && trans[1]) begin
      err = (size > 3'd2) || (addr >= 32'(DEPTH*4)) || ((addr % (32'd1 << size)) != 0);
      d = 32'd0;
      if (wr) pend_wdata = wdata;
      if (!err && wr) begin
        nb = 1 << size;
        for (int b = 0; b < nb; b++) begin
          ba = int'(addr) + b;
          mem_m[tgt][ba] = wdata[8*(ba%4) +: 8];
        end
      end else if (!err) begin
        d = model_word(tgt, addr);
      end
      exp_q.push_back({err, err ? 4'd1 : (tgt ? 4'd3 : 4'd0), d});
    end
  endtask

  task automatic nop();
    issue(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 3'd2, 32'd0);
  endtask

  // Offers a write to u_dut0 while the bus is stalled, then withdraws it.
  task automatic present_stale(input int n);
    b_hwdata = pend_wdata;
    b_tgt    = 1'b0;
    b_hsel   = 1'b1;
    b_htrans = 2'b10;
    b_hwrite = 1'b1;
    b_haddr  = 32'h60;
    b_hsize  = 3'd2;
    repeat (n) begin
      @(negedge hclk);
      check("stall_hready", 32'(bus_hready), 32'd0);
      @(posedge hclk);
      #1;
    end
    b_hsel   = 1'b0;
    b_htrans = 2'b00;
  endtask

  // ---------------- monitor ----------------
  logic         dp_active = 1'b0;
  int           waits     = 0;
  logic [W-1:0] e;

  always @(negedge hclk) begin
    if (!rst_n) begin
      dp_active = 1'b0;
      waits     = 0;
    end else begin
      if (dp_active) begin
        if (exp_q.size() == 0) begin
          check("unexpected_dphase", 32'd1, 32'd0);
          dp_active = 1'b0;
        end else begin
          e = exp_q[0];
          check("hresp", 32'(bus_hresp), e[36] ? 32'd1 : 32'd0);
          if (!bus_hready) begin
            waits++;
          end else begin
            void'(exp_q.pop_front());
            check("hrdata", bus_hrdata, e[31:0]);
            check("wait_cycles", 32'(waits), 32'(e[35:32]));
            dp_active = 1'b0;
          end
        end
      end else begin
        check("idle_hready", 32'(bus_hready), 32'd1);
        check("idle_hresp", 32'(bus_hresp), 32'd0);
        check("idle_hrdata", bus_hrdata, 32'd0);
      end
      if (bus_hready && b_hsel && b_htrans[1]) begin
        dp_active = 1'b1;
        waits     = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic        tgt, sel, wr;
    logic [1:0]  trans;
    logic [2:0]  size;
    logic [31:0] addr;
    int          k;

    b_tgt = 1'b0; b_hsel = 1'b0; b_htrans = 2'b00; b_hwrite = 1'b0;
    b_haddr = 32'd0; b_hsize = 3'd2; b_hwdata = 32'd0;
    do_reset(3);

    // reset state and a first read
    @(negedge hclk);
    check("reset_hready0", 32'(bus0.hready_out), 32'd1);
    check("reset_hready1", 32'(bus1.hready_out), 32'd1);
    check("reset_hresp0", 32'(bus0.hresp), 32'd0);
    check("reset_hrdata1", bus1.hrdata, 32'd0);
    @(posedge hclk); #1;
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h000, 3'd2, 32'd0);

    // back-to-back write then read
    issue(1'b0, 1'b1, 2'b10, 1'b1, 32'h010, 3'd2, 32'hDEADBEEF);
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h010, 3'd2, 32'd0);

    // byte / half lanes
    issue(1'b0, 1'b1, 2'b10, 1'b1, 32'h020, 3'd2, 32'h11223344);
    issue(1'b0, 1'b1, 2'b11, 1'b1, 32'h022, 3'd0, 32'h00AA0000);
    issue(1'b0, 1'b1, 2'b11, 1'b1, 32'h020, 3'd1, 32'h00005566);
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h020, 3'd2, 32'd0);

    // error responses
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h003, 3'd2, 32'd0);
    issue(1'b0, 1'b1, 2'b10, 1'b1, 32'h1000, 3'd2, 32'hBADBAD00);
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h000, 3'd3, 32'd0);
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h000, 3'd2, 32'd0);
    issue(1'b1, 1'b1, 2'b10, 1'b1, 32'h001, 3'd1, 32'h0000FFFF);
    nop();

    // wait states, and an address phase offered while stalled
    issue(1'b1, 1'b1, 2'b10, 1'b1, 32'h040, 3'd2, 32'h12345678);
    present_stale(2);
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h040, 3'd2, 32'd0);
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h060, 3'd2, 32'd0);
    nop();

    // no-transfer cycles, then reset during a waited write
    issue(1'b1, 1'b1, 2'b00, 1'b1, 32'h050, 3'd2, 32'd0);
    issue(1'b1, 1'b1, 2'b01, 1'b1, 32'h050, 3'd2, 32'd0);
    issue(1'b1, 1'b0, 2'b10, 1'b1, 32'h050, 3'd2, 32'd0);
    issue(1'b1, 1'b1, 2'b10, 1'b1, 32'h050, 3'd2, 32'hCAFEF00D);
    b_hwdata = pend_wdata;
    b_hsel   = 1'b0;
    b_htrans = 2'b00;
    @(posedge hclk); #1;
    do_reset(2);
    issue(1'b1, 1'b1, 2'b10, 1'b0, 32'h050, 3'd2, 32'd0);
    issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h010, 3'd2, 32'd0);
    nop();

    // randomized traffic over a small address pool
    for (int i = 0; i < 400; i++) begin
      tgt   = 1'($urandom_range(0, 1));
      sel   = ($urandom_range(0, 9) != 0);
      k     = $urandom_range(0, 9);
      trans = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : (k < 6) ? 2'b10 : 2'b11;
      wr    = 1'($urandom_range(0, 1));
      size  = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      addr  = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(0, 3));
      if (size <= 3'd2 && $urandom_range(0, 9) < 7)
        addr = addr & ~((32'd1 << size) - 32'd1);
      if ($urandom_range(0, 19) == 0)
        addr = addr | (32'd1 << $urandom_range(12, 31));
      issue(tgt, sel, trans, wr, addr, size, $urandom());
    end
    nop();
    nop();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge hclk);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
